// File: rtl/mips_mc_core_if.sv
// mips_mc_core_if: valid/ready word-addressed memory bus between the core and RAM
interface mips_mc_core_if #(parameter int ADDR_W = 7);
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic [31:0]       MEM_RDATA;
  logic              MEM_READY;
  modport master(output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, input MEM_RDATA, MEM_READY);
  modport slave(input MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, output MEM_RDATA, MEM_READY);
endinterface

// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS subset with wait-state memory handshake, illegal-op halt and debug read port
module mips_mc_core #(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  mips_mc_core_if.master    mem,
  input  logic [4:0]        DBG_RADDR,
  output logic [31:0]       DBG_RDATA,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              RETIRE,
  output logic              HALTED,
  output logic              ILLEGAL
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                         OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101,
                         F_XOR = 6'b100110, F_SLT = 6'b101010, F_SLL = 6'b000000, F_SRL = 6'b000010,
                         F_JR = 6'b001000;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, alu;
  logic              ill_q, ill_d;
  logic [31:0]       rf_q [32];
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [31:0]       rf_wd;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, sh;
  logic [31:0]       sext, zext;
  logic              legal;
  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign sh     = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext   = {16'd0, ir_q[15:0]};
  assign legal  = (op == OP_R) ? (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL, F_JR})
                               : (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL});
  assign DBG_RDATA = (DBG_RADDR == 5'd0) ? 32'd0 : rf_q[DBG_RADDR];
  assign PC_OUT    = pc_q;
  assign HALTED    = (state_q == HALT);
  assign ILLEGAL   = ill_q;
  // addi/lw/sw share the sign-extended add, which is also the memory address
  always_comb begin
    alu = a_q + sext;
    case (op)
      OP_R:
        case (funct)
          F_SUB:   alu = a_q - b_q;
          F_AND:   alu = a_q & b_q;
          F_OR:    alu = a_q | b_q;
          F_XOR:   alu = a_q ^ b_q;
          F_SLT:   alu = {31'd0, $signed(a_q) < $signed(b_q)};
          F_SLL:   alu = b_q << sh;
          F_SRL:   alu = b_q >> sh;
          default: alu = a_q + b_q;
        endcase
      OP_ANDI: alu = a_q & zext;
      OP_ORI:  alu = a_q | zext;
      OP_LUI:  alu = {ir_q[15:0], 16'd0};
      default: ;
    endcase
  end
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_d         = alu_q;
    ill_d         = ill_q;
    rf_we         = 1'b0;
    rf_wa         = (op == OP_R) ? rd : rt;
    rf_wd         = alu_q;
    RETIRE        = 1'b0;
    mem.MEM_REQ   = 1'b0;
    mem.MEM_WE    = 1'b0;
    mem.MEM_ADDR  = pc_q;
    mem.MEM_WDATA = b_q;
    case (state_q)
      FETCH: begin
        mem.MEM_REQ = 1'b1;
        if (mem.MEM_READY) begin
          ir_d    = mem.MEM_RDATA;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = EXEC;
        if (!legal) begin
          state_d = HALT;
          ill_d   = 1'b1;
        end else if (op == OP_J || op == OP_JAL) begin
          pc_d    = ir_q[ADDR_W-1:0];
          rf_we   = (op == OP_JAL);
          rf_wa   = 5'd31;
          rf_wd   = 32'(pc_q);
          RETIRE  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_d   = alu;
        state_d = WB;
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_d    = ((a_q == b_q) == (op == OP_BEQ)) ? pc_q + sext[ADDR_W-1:0] : pc_q;
          RETIRE  = 1'b1;
          state_d = FETCH;
        end else if (op == OP_R && funct == F_JR) begin
          pc_d    = a_q[ADDR_W-1:0];
          RETIRE  = 1'b1;
          state_d = FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = MEM;
        end
      end
      MEM: begin
        mem.MEM_REQ  = 1'b1;
        mem.MEM_WE   = (op == OP_SW);
        mem.MEM_ADDR = alu_q[ADDR_W-1:0];
        if (mem.MEM_READY) begin
          alu_d   = mem.MEM_RDATA;
          RETIRE  = (op == OP_SW);
          state_d = (op == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        RETIRE  = 1'b1;
        state_d = FETCH;
      end
      default: ;
    endcase
    // a cycle with reset asserted never issues a request or retires
    if (RST) begin
      mem.MEM_REQ = 1'b0;
      mem.MEM_WE  = 1'b0;
      RETIRE      = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      ill_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      ill_q   <= ill_d;
      if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
    end
  end
endmodule
